// File: rtl/imm_gen_pipe_if.sv
// Fetch-to-decode immediate generator bundle: input instruction/PC handshake and
// decoded output handshake, seen from the environment (master) and the block (slave).
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst_in;
  logic [XLEN-1:0]  pc_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      inst_out;
  logic [XLEN-1:0]  imm_out;
  logic [FMT_W-1:0] fmt_out;
  logic [XLEN-1:0]  target_out;

  modport slave (
    input  in_valid, inst_in, pc_in, out_ready,
    output in_ready, out_valid, inst_out, imm_out, fmt_out, target_out
  );

  modport master (
    output in_valid, inst_in, pc_in, out_ready,
    input  in_ready, out_valid, inst_out, imm_out, fmt_out, target_out
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator, 1-cycle latency; output register + 1 skid entry, in_ready registered (skid empty).
// Optional compressed-instruction decode when IMM_GEN_PIPE_RVC_EN is defined.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_gen_pipe_if.slave bus
);

  localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_U    = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_J    = FMT_W'(5);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } req_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic void decode32(input logic [31:0] i,
                                   output logic [FMT_W-1:0] fmt,
                                   output logic [XLEN-1:0] imm);
    // Unknown opcodes fall back to I, matching the old combinational generator.
    fmt = FMT_I;
    imm = sext32({{20{i[31]}}, i[31:20]});
    case (i[6:0])
      7'b0100011: begin
        fmt = FMT_S;
        imm = sext32({{20{i[31]}}, i[31:25], i[11:7]});
      end
      7'b1100011: begin
        fmt = FMT_B;
        imm = sext32({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        fmt = FMT_U;
        imm = sext32({i[31:12], 12'b0});
      end
      7'b1101111: begin
        fmt = FMT_J;
        imm = sext32({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
      end
      7'b0110011, 7'b0111011: begin
        fmt = FMT_NONE;
        imm = '0;
      end
      default: ;
    endcase
  endfunction

`ifdef IMM_GEN_PIPE_RVC_EN
  function automatic void decode16(input logic [15:0] i,
                                   output logic [FMT_W-1:0] fmt,
                                   output logic [XLEN-1:0] imm);
    fmt = FMT_NONE;
    imm = '0;
    if (i[1:0] == 2'b01) begin
      case (i[15:13])
        3'b000, 3'b010: begin
          fmt = FMT_I;
          imm = sext32({{26{i[12]}}, i[12], i[6:2]});
        end
        3'b011: begin
          // rd=2 is C.ADDI16SP, rd=0 is reserved
          if (i[11:7] != 5'd0 && i[11:7] != 5'd2) begin
            fmt = FMT_U;
            imm = sext32({{14{i[12]}}, i[12], i[6:2], 12'b0});
          end
        end
        3'b001, 3'b101: begin
          // funct3=001 is C.JAL only on RV32; on RV64 it encodes C.ADDIW
          if (i[15:13] == 3'b101 || XLEN == 32) begin
            fmt = FMT_J;
            imm = sext32({{20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2],
                          i[11], i[5:3], 1'b0});
          end
        end
        3'b110, 3'b111: begin
          fmt = FMT_B;
          imm = sext32({{23{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0});
        end
        default: ;
      endcase
    end
  endfunction
`endif

  logic             out_vld_q, skid_vld_q, in_rdy_q;
  req_t             skid_q;
  logic [31:0]      inst_q;
  logic [XLEN-1:0]  imm_q, tgt_q;
  logic [FMT_W-1:0] fmt_q;

  logic             acc_in, out_free, load_out, skid_load;
  logic             out_vld_d, skid_vld_d;
  req_t             new_req, cand;
  logic [FMT_W-1:0] fmt_c;
  logic [XLEN-1:0]  imm_c, tgt_c;

  assign new_req  = '{inst: bus.inst_in, pc: bus.pc_in};
  assign acc_in   = bus.in_valid & in_rdy_q;
  assign out_free = ~out_vld_q | bus.out_ready;
  // Skid entry is older than anything arriving now, so it always wins the output register.
  assign cand      = skid_vld_q ? skid_q : new_req;
  assign load_out  = out_free & (skid_vld_q | acc_in);
  assign skid_load = acc_in & (~out_free | skid_vld_q);

  always_comb begin
    fmt_c = FMT_NONE;
    imm_c = '0;
`ifdef IMM_GEN_PIPE_RVC_EN
    if (cand.inst[1:0] != 2'b11) decode16(cand.inst[15:0], fmt_c, imm_c);
    else                         decode32(cand.inst, fmt_c, imm_c);
`else
    decode32(cand.inst, fmt_c, imm_c);
`endif
    tgt_c = cand.pc + imm_c;
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (out_free) begin
      out_vld_d  = skid_vld_q | acc_in;
      skid_vld_d = skid_vld_q & acc_in;
    end else if (acc_in) begin
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b0;
      skid_q     <= '0;
      inst_q     <= '0;
      imm_q      <= '0;
      fmt_q      <= '0;
      tgt_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= ~skid_vld_d;
      if (skid_load) skid_q <= new_req;
      if (load_out) begin
        inst_q <= cand.inst;
        imm_q  <= imm_c;
        fmt_q  <= fmt_c;
        tgt_q  <= tgt_c;
      end
    end
  end

  assign bus.in_ready   = in_rdy_q;
  assign bus.out_valid  = out_vld_q;
  assign bus.inst_out   = inst_q;
  assign bus.imm_out    = imm_q;
  assign bus.fmt_out    = fmt_q;
  assign bus.target_out = tgt_q;

endmodule
